// File: rtl/xbus_timer_pkg.sv
// Shared register map, CTRL field positions and byte-enable merge helper for xbus_timer.
package xbus_timer_pkg;

    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_STATUS   = 3'd5,
        REG_WDOG     = 3'd6,
        REG_RSVD     = 3'd7
    } timer_reg_e;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_RELOAD_BIT   = 2;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int STATUS_PEND_BIT   = 0;

    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/xbus_timer_if.sv
// xbus slave-side signal bundle; the core/decoder side uses master, each slave uses slave.
interface xbus_timer_if;
    logic        xbus_cs;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;

    modport master (output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
                    input  xbus_rdata);
    modport slave  (input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
                    output xbus_rdata);
endinterface

// File: rtl/xbus_timer_prescaler.sv
// Prescaler for the machine timer: counts 0..prescale while enabled and ticks on the last count.
module xbus_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_pre_cnt;

    assign o_tick = i_en && (r_pre_cnt == i_prescale);

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/xbus_timer.sv
// Machine timer xbus slave: 64-bit mtime/compare, sticky match, registered irq, tear-free reads.
// Optional watchdog enabled by defining XBUS_TIMER_WDOG_EN.
module xbus_timer
    import xbus_timer_pkg::*;
#(
    parameter int PRESCALE_W = 8,
    parameter int WDOG_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    xbus_timer_if.slave   bus,
    output logic          irq,
    output logic          wdog_rst
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_cmp;
    logic [31:0]           r_hi_shadow;
    logic                  r_en;
    logic                  r_irq_en;
    logic                  r_reload;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_pend;
    logic                  r_irq;

    logic                  w_wr;
    logic                  w_rd;
    timer_reg_e            w_reg;
    logic                  w_wr_lo;
    logic                  w_wr_hi;
    logic                  w_w1c;
    logic                  w_tick;
    logic                  w_match;
    logic [31:0]           w_ctrl_rd;
    logic [31:0]           w_ctrl_wr;
    logic [31:0]           w_wdog_rd;
    logic                  w_unused_bits;

    assign w_wr    = bus.xbus_cs &&  bus.xbus_we;
    assign w_rd    = bus.xbus_cs && !bus.xbus_we;
    assign w_reg   = timer_reg_e'(bus.xbus_addr[4:2]);
    assign w_wr_lo = w_wr && (w_reg == REG_MTIME_LO);
    assign w_wr_hi = w_wr && (w_reg == REG_MTIME_HI);
    assign w_w1c   = w_wr && (w_reg == REG_STATUS)
                     && bus.xbus_be[STATUS_PEND_BIT/8] && bus.xbus_wdata[STATUS_PEND_BIT];
    assign w_match = r_en && (r_mtime >= r_cmp);

    assign w_unused_bits = ^{bus.xbus_addr[31:5], bus.xbus_addr[1:0],
                             w_ctrl_wr[31:CTRL_PRESCALE_LSB+PRESCALE_W], w_ctrl_wr[7:3]};

    xbus_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk        (clk),
        .rst_n      (rst),
        .i_en       (r_en),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_ctrl_rd                                    = '0;
        w_ctrl_rd[CTRL_EN_BIT]                       = r_en;
        w_ctrl_rd[CTRL_IRQ_EN_BIT]                   = r_irq_en;
        w_ctrl_rd[CTRL_RELOAD_BIT]                   = r_reload;
        w_ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W]   = r_prescale;
    end

    assign w_ctrl_wr = apply_be(w_ctrl_rd, bus.xbus_wdata, bus.xbus_be);

    // A bus write to either mtime half suppresses that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime <= '0;
        end else if (w_wr_lo || w_wr_hi) begin
            if (w_wr_lo) r_mtime[31:0]  <= apply_be(r_mtime[31:0],  bus.xbus_wdata, bus.xbus_be);
            if (w_wr_hi) r_mtime[63:32] <= apply_be(r_mtime[63:32], bus.xbus_wdata, bus.xbus_be);
        end else if (w_tick) begin
            r_mtime <= (r_reload && (r_mtime == r_cmp)) ? '0 : r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp       <= '1;
            r_hi_shadow <= '0;
            r_en        <= 1'b0;
            r_irq_en    <= 1'b0;
            r_reload    <= 1'b0;
            r_prescale  <= '0;
            r_pend      <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_CMP_LO))
                r_cmp[31:0]  <= apply_be(r_cmp[31:0],  bus.xbus_wdata, bus.xbus_be);
            if (w_wr && (w_reg == REG_CMP_HI))
                r_cmp[63:32] <= apply_be(r_cmp[63:32], bus.xbus_wdata, bus.xbus_be);
            if (w_wr && (w_reg == REG_CTRL)) begin
                r_en       <= w_ctrl_wr[CTRL_EN_BIT];
                r_irq_en   <= w_ctrl_wr[CTRL_IRQ_EN_BIT];
                r_reload   <= w_ctrl_wr[CTRL_RELOAD_BIT];
                r_prescale <= w_ctrl_wr[CTRL_PRESCALE_LSB +: PRESCALE_W];
            end
            if (w_rd && (w_reg == REG_MTIME_LO))
                r_hi_shadow <= r_mtime[63:32];
            r_pend <= w_match || (r_pend && !w_w1c);
            r_irq  <= r_pend && r_irq_en;
        end
    end

    assign irq = r_irq;

`ifdef XBUS_TIMER_WDOG_EN
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_rst;
    logic              w_wr_wdog;

    assign w_wr_wdog = w_wr && (w_reg == REG_WDOG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
            r_wdog_rst <= 1'b0;
        end else if (w_wr_wdog) begin
            r_wdog_cnt <= bus.xbus_wdata[WDOG_W-1:0];
            r_wdog_rst <= 1'b0;
        end else if (r_wdog_cnt != '0) begin
            r_wdog_cnt <= r_wdog_cnt - WDOG_W'(1);
            r_wdog_rst <= (r_wdog_cnt == WDOG_W'(1));
        end else begin
            r_wdog_rst <= 1'b0;
        end
    end

    assign w_wdog_rd = 32'(r_wdog_cnt);
    assign wdog_rst  = r_wdog_rst;
`else
    logic [WDOG_W-1:0] w_wdog_unused;

    assign w_wdog_unused = '0;
    assign w_wdog_rd     = '0;
    assign wdog_rst      = 1'b0;
`endif

    // NOTE: default assigned first so no path leaves rdata unassigned (no latch).
    always_comb begin
        bus.xbus_rdata = '0;
        if (w_rd) begin
            case (w_reg)
                REG_MTIME_LO: bus.xbus_rdata = r_mtime[31:0];
                REG_MTIME_HI: bus.xbus_rdata = r_hi_shadow;
                REG_CMP_LO:   bus.xbus_rdata = r_cmp[31:0];
                REG_CMP_HI:   bus.xbus_rdata = r_cmp[63:32];
                REG_CTRL:     bus.xbus_rdata = w_ctrl_rd;
                REG_STATUS:   bus.xbus_rdata = {31'd0, r_pend};
                REG_WDOG:     bus.xbus_rdata = w_wdog_rd;
                REG_RSVD:     bus.xbus_rdata = '0;
                default:      bus.xbus_rdata = '0;
            endcase
        end
    end

endmodule
